// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and width helpers for the fifo slice
package fifo_pkg;
  localparam int default_length = 8;
  localparam int default_bit_width = 8;
  function automatic int level_width(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int ptr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_if.sv
// fifo_if: producer/consumer handshake bundle for the fifo
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int length = default_length,
  parameter int bit_width = default_bit_width
);
  localparam int lw = level_width(length);
  logic write;
  logic [bit_width-1:0] write_data;
  logic read;
  logic [bit_width-1:0] read_data;
  logic read_valid;
  logic full;
  logic empty;
  logic [lw-1:0] level;
  logic overflow;
  logic underflow;
  modport master (
    output write, write_data, read,
    input read_data, read_valid, full, empty, level, overflow, underflow
  );
  modport slave (
    input write, write_data, read,
    output read_data, read_valid, full, empty, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: register array with one write port and one registered read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int length = default_length,
  parameter int bit_width = default_bit_width,
  parameter int pw = ptr_width(length)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [pw-1:0] waddr,
  input  logic [bit_width-1:0] wdata,
  input  logic re,
  input  logic [pw-1:0] raddr,
  output logic [bit_width-1:0] rdata
);
  logic [bit_width-1:0] mem [length];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo.sv
// fifo: single-clock fifo with level, full/empty and drop-pulse flags
module fifo
  import fifo_pkg::*;
#(
  parameter int length = default_length,
  parameter int bit_width = default_bit_width
) (
  input logic clk,
  input logic rst,
  fifo_if.slave bus
);
  localparam int pw = ptr_width(length);
  localparam int lw = level_width(length);
  localparam logic [pw-1:0] last = pw'(length - 1);
  localparam logic [lw-1:0] cap = lw'(length);
  logic [pw-1:0] wptr, rptr;
  logic [lw-1:0] level;
  logic read_accept, write_accept;
  // a pop frees a slot in the same edge, so a full fifo still takes a write alongside a read
  always_comb begin
    read_accept = bus.read & ~bus.empty;
    write_accept = bus.write & (~bus.full | read_accept);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      bus.read_valid <= 1'b0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (write_accept) wptr <= wptr == last ? '0 : wptr + 1'b1;
      if (read_accept) rptr <= rptr == last ? '0 : rptr + 1'b1;
      level <= level + lw'(write_accept) - lw'(read_accept);
      bus.read_valid <= read_accept;
      bus.overflow <= bus.write & ~write_accept;
      bus.underflow <= bus.read & ~read_accept;
    end
  assign bus.level = level;
  assign bus.full = level == cap;
  assign bus.empty = level == '0;
  fifo_mem #(.length(length), .bit_width(bit_width), .pw(pw)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(write_accept),
    .waddr(wptr),
    .wdata(bus.write_data),
    .re(read_accept),
    .raddr(rptr),
    .rdata(bus.read_data)
  );
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: scoreboard-driven checks of ordering, flags and reset for fifo
module tb_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [3:0] q[$];
  int mlevel = 0;
  logic [3:0] exp_rd = '0;
  logic exp_rv = 1'b0, exp_ov = 1'b0, exp_un = 1'b0;
  fifo_if #(.length(8), .bit_width(4)) bus ();
  fifo #(.length(8), .bit_width(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    q.delete();
    mlevel = 0;
    exp_rd = '0;
    exp_rv = 1'b0;
    exp_ov = 1'b0;
    exp_un = 1'b0;
  endtask
  task automatic drive(input logic w, input logic [3:0] wd, input logic r);
    logic ra, wa;
    ra = r && mlevel > 0;
    wa = w && (mlevel < 8 || ra);
    bus.write = w;
    bus.write_data = wd;
    bus.read = r;
    if (ra) exp_rd = q.pop_front();
    if (wa) q.push_back(wd);
    exp_rv = ra;
    exp_ov = w && !wa;
    exp_un = r && !ra;
    mlevel = mlevel + int'(wa) - int'(ra);
    step();
    bus.write = 1'b0;
    bus.read = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    bus.write = 1'b0;
    bus.write_data = '0;
    bus.read = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b1;
    step();
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", bus.full); end
    tests++; if (bus.level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    tests++; if (bus.read_data !== 4'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", bus.read_data); end
    tests++; if (bus.read_valid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b want 0", bus.read_valid); end
  endtask
  task automatic test_single();
    drive(1'b1, 4'h5, 1'b0);
    tests++; if (bus.level !== 4'd1) begin fails++; $display("FAIL single_level: got %0d want 1", bus.level); end
    drive(1'b0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b1);
    tests++; if (bus.read_valid !== 1'b1 || bus.read_data !== 4'h5) begin fails++; $display("FAIL single_pop: got v=%b d=%h want v=1 d=5", bus.read_valid, bus.read_data); end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL single_empty: got %b want 1", bus.empty); end
    drive(1'b0, 4'h0, 1'b0);
    tests++; if (bus.read_valid !== 1'b0 || bus.read_data !== 4'h5) begin fails++; $display("FAIL single_hold: got v=%b d=%h want v=0 d=5", bus.read_valid, bus.read_data); end
  endtask
  task automatic test_burst();
    drive(1'b1, 4'h9, 1'b0);
    drive(1'b1, 4'hC, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      tests++; if (bus.read_valid !== exp_rv || bus.read_data !== exp_rd || bus.underflow !== exp_un) begin fails++; $display("FAIL burst_pop%0d: got v=%b d=%h u=%b want v=%b d=%h u=%b", i, bus.read_valid, bus.read_data, bus.underflow, exp_rv, exp_rd, exp_un); end
    end
    tests++; if (bus.underflow !== 1'b1 || bus.read_data !== 4'hC) begin fails++; $display("FAIL burst_underflow: got u=%b d=%h want u=1 d=c", bus.underflow, bus.read_data); end
  endtask
  task automatic test_fill_overflow();
    for (int i = 0; i < 8; i++) drive(1'b1, 4'(i), 1'b0);
    tests++; if (bus.full !== 1'b1 || bus.level !== 4'd8) begin fails++; $display("FAIL fill_full: got f=%b l=%0d want f=1 l=8", bus.full, bus.level); end
    drive(1'b1, 4'hF, 1'b0);
    tests++; if (bus.overflow !== 1'b1 || bus.level !== 4'd8) begin fails++; $display("FAIL fill_overflow: got o=%b l=%0d want o=1 l=8", bus.overflow, bus.level); end
    drive(1'b0, 4'h0, 1'b0);
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL overflow_pulse: got %b want 0", bus.overflow); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      tests++; if (bus.read_valid !== 1'b1 || bus.read_data !== 4'(i)) begin fails++; $display("FAIL drain%0d: got v=%b d=%h want v=1 d=%h", i, bus.read_valid, bus.read_data, 4'(i)); end
    end
    tests++; if (bus.empty !== 1'b1 || bus.level !== 4'd0) begin fails++; $display("FAIL drain_empty: got e=%b l=%0d want e=1 l=0", bus.empty, bus.level); end
  endtask
  task automatic test_full_rw_wrap();
    for (int i = 0; i < 8; i++) drive(1'b1, 4'(i + 1), 1'b0);
    drive(1'b1, 4'hA, 1'b1);
    tests++; if (bus.level !== 4'd8 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin fails++; $display("FAIL fullrw_level: got l=%0d f=%b o=%b want l=8 f=1 o=0", bus.level, bus.full, bus.overflow); end
    tests++; if (bus.read_valid !== 1'b1 || bus.read_data !== 4'h1) begin fails++; $display("FAIL fullrw_data: got v=%b d=%h want v=1 d=1", bus.read_valid, bus.read_data); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      tests++; if (bus.read_valid !== 1'b1 || bus.read_data !== exp_rd) begin fails++; $display("FAIL wrap_drain%0d: got v=%b d=%h want v=1 d=%h", i, bus.read_valid, bus.read_data, exp_rd); end
    end
    tests++; if (bus.read_data !== 4'hA || bus.empty !== 1'b1) begin fails++; $display("FAIL wrap_last: got d=%h e=%b want d=a e=1", bus.read_data, bus.empty); end
  endtask
  task automatic test_empty_rw();
    drive(1'b1, 4'h3, 1'b1);
    tests++; if (bus.underflow !== 1'b1 || bus.level !== 4'd1 || bus.read_valid !== 1'b0) begin fails++; $display("FAIL empty_rw: got u=%b l=%0d v=%b want u=1 l=1 v=0", bus.underflow, bus.level, bus.read_valid); end
    drive(1'b0, 4'h0, 1'b1);
    tests++; if (bus.read_valid !== 1'b1 || bus.read_data !== 4'h3) begin fails++; $display("FAIL empty_rw_pop: got v=%b d=%h want v=1 d=3", bus.read_valid, bus.read_data); end
  endtask
  task automatic test_async_reset();
    drive(1'b1, 4'h6, 1'b0);
    drive(1'b1, 4'h7, 1'b0);
    drive(1'b0, 4'h0, 1'b1);
    drive(1'b1, 4'h8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    tests++; if (bus.empty !== 1'b1 || bus.level !== 4'd0 || bus.full !== 1'b0) begin fails++; $display("FAIL async_flags: got e=%b l=%0d f=%b want e=1 l=0 f=0", bus.empty, bus.level, bus.full); end
    tests++; if (bus.read_data !== 4'h0 || bus.read_valid !== 1'b0) begin fails++; $display("FAIL async_rdata: got d=%h v=%b want d=0 v=0", bus.read_data, bus.read_valid); end
    step();
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b1);
    tests++; if (bus.underflow !== 1'b1 || bus.read_valid !== 1'b0 || bus.read_data !== 4'h0) begin fails++; $display("FAIL async_stale: got u=%b v=%b d=%h want u=1 v=0 d=0", bus.underflow, bus.read_valid, bus.read_data); end
    drive(1'b1, 4'hB, 1'b0);
    drive(1'b0, 4'h0, 1'b1);
    tests++; if (bus.read_valid !== 1'b1 || bus.read_data !== 4'hB) begin fails++; $display("FAIL async_resume: got v=%b d=%h want v=1 d=b", bus.read_valid, bus.read_data); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
      tests++; if (bus.read_valid !== exp_rv || bus.read_data !== exp_rd) begin fails++; $display("FAIL b2b_data%0d: got v=%b d=%h want v=%b d=%h", i, bus.read_valid, bus.read_data, exp_rv, exp_rd); end
      tests++; if (bus.level !== 4'(mlevel) || bus.full !== (mlevel == 8) || bus.empty !== (mlevel == 0)) begin fails++; $display("FAIL b2b_level%0d: got l=%0d f=%b e=%b want l=%0d", i, bus.level, bus.full, bus.empty, mlevel); end
      tests++; if (bus.overflow !== exp_ov || bus.underflow !== exp_un) begin fails++; $display("FAIL b2b_drop%0d: got o=%b u=%b want o=%b u=%b", i, bus.overflow, bus.underflow, exp_ov, exp_un); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fill_overflow();
    test_full_rw_wrap();
    test_empty_rw();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
